// File: rtl/mem_stage.sv
// MEM stage of the 5-stage core: issues word loads/stores, stalls upstream while an access is
// outstanding, resolves branch/jump redirects, and holds the MEM/WB pipeline register.
// Latency: load/store = 1 + memory wait cycles; ALU ops and redirects pass in a single cycle.
// Backpressure: mem_stall freezes PC..EX/MEM while waiting; an access is aborted after TIMEOUT cycles.
module mem_stage #(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] reg2_in,
  input  logic [31:0] instr_in,
  input  logic        RegWrite_in,
  input  logic        MemToReg_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        Branch_in,
  input  logic        Jump_in,
  input  logic [31:0] pcBranch_in,
  input  logic [31:0] jumpaddr_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        pc_redirect,
  output logic [31:0] pc_target,
  output logic [31:0] pc_wb,
  output logic [31:0] alu_result_wb,
  output logic [31:0] mem_rdata_wb,
  output logic [31:0] instr_wb,
  output logic        RegWrite_wb,
  output logic        MemToReg_wb,
  output logic        err_timeout,
  output logic        err_align
);

  localparam int            CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  logic        w_memop;
  logic        w_misalign;
  logic        w_access;
  logic        w_is_load;
  logic        w_req;
  logic        w_stall;
  logic        w_timeout;
  logic        w_ack_done;
  logic        w_redir;
  logic [31:0] w_target;
  logic [31:0] w_load_data;

  assign w_memop    = MemRead_in | MemWrite_in;
  assign w_misalign = w_memop & (alu_result_in[1:0] != 2'b00);
  assign w_access   = w_memop & ~w_misalign;
  // Read+write together behaves as a store, so it never returns load data.
  assign w_is_load  = MemRead_in & ~MemWrite_in;
  assign w_ack_done = (r_state == S_WAIT) & dmem_ack;
  assign w_timeout  = (r_state == S_WAIT) & ~dmem_ack & (r_cnt == CNT_MAX);

  // Next-state, wait counter, request and stall generation.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_req       = 1'b0;
    w_stall     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Any ack seen here belongs to nobody and is ignored.
        if (w_access) begin
          w_req       = 1'b1;
          w_stall     = 1'b1;
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = CW'(1);
        end
      end
      S_WAIT: begin
        w_req = 1'b1;
        if (dmem_ack || (r_cnt == CNT_MAX)) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_stall   = 1'b1;
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // FSM state and wait-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Reset forces every combinational output low at once, so an in-flight request drops immediately.
  assign dmem_req   = w_req & rst_n;
  assign mem_stall  = w_stall & rst_n;
  assign dmem_we    = dmem_req & MemWrite_in;
  assign dmem_addr  = dmem_req ? alu_result_in : 32'h0;
  assign dmem_wdata = dmem_req ? reg2_in : 32'h0;

  // Redirect resolution: jump wins over a taken branch (taken when the compare result is zero).
  always_comb begin
    w_redir  = 1'b0;
    w_target = 32'h0;
    if (Jump_in) begin
      w_redir  = 1'b1;
      w_target = jumpaddr_in;
    end else if (Branch_in && (alu_result_in == 32'h0)) begin
      w_redir  = 1'b1;
      w_target = pcBranch_in;
    end
  end

  assign pc_redirect = w_redir & rst_n;
  assign pc_target   = rst_n ? w_target : 32'h0;

  // When a load is not stalled it either got its ack, timed out, or was misaligned.
  assign w_load_data = w_ack_done ? dmem_rdata : ERR_DATA;

  // MEM/WB register: bubble while stalled, otherwise advance the instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_wb         <= 32'h0;
      alu_result_wb <= 32'h0;
      mem_rdata_wb  <= 32'h0;
      instr_wb      <= 32'h0;
      RegWrite_wb   <= 1'b0;
      MemToReg_wb   <= 1'b0;
    end else if (w_stall) begin
      instr_wb    <= 32'h0;
      RegWrite_wb <= 1'b0;
      MemToReg_wb <= 1'b0;
    end else begin
      pc_wb         <= pc_in;
      alu_result_wb <= alu_result_in;
      mem_rdata_wb  <= w_is_load ? w_load_data : 32'h0;
      instr_wb      <= instr_in;
      RegWrite_wb   <= RegWrite_in;
      MemToReg_wb   <= MemToReg_in;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_timeout <= 1'b0;
      err_align   <= 1'b0;
    end else begin
      if (w_timeout) err_timeout <= 1'b1;
      if ((r_state == S_IDLE) && w_misalign) err_align <= 1'b1;
    end
  end

endmodule
